// File: rtl/rename_register_file_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rename_register_file_pkg
// Description : Shared widths, boolean constants and small helpers for the
//               rename register file and its read ports.
// Revision    : 1.0 - initial release
// ============================================================================
package rename_register_file_pkg;

    localparam int  REG_ADDR_W = 5;
    localparam int  DATA_W     = 32;
    localparam logic TRUE      = 1'b1;
    localparam logic FALSE     = 1'b0;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0]     word_t;

    // x0 is hard-wired to zero: never renamed, never written
    function automatic logic is_x0(input reg_addr_t addr);
        return (addr == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rename_register_file_read_port.sv
`default_nettype none
// ============================================================================
// Module      : regfile_read_port
// Description : One combinational source lookup into the register/tag state.
//               Returns either the committed value or the ROB entry to wait
//               on. With REGFILE_BYPASS_EN defined, a lookup whose producer is
//               committing this cycle returns the commit value directly.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_read_port
    import rename_register_file_pkg::*;
#(
    parameter int REG_NUM = 32,
    parameter int ENTRY_W = 5
) (
    input  logic [REG_ADDR_W-1:0]            addr,
    input  logic [REG_NUM-1:0]               busy_vec,
    input  logic [REG_NUM-1:0][ENTRY_W-1:0]  tag_vec,
    input  logic [REG_NUM-1:0][DATA_W-1:0]   value_vec,
    input  logic                             commit_fire,
    input  logic [ENTRY_W-1:0]               commit_entry,
    input  logic [DATA_W-1:0]                commit_value,
    output logic                             busy,
    output logic [ENTRY_W-1:0]               entry,
    output logic [DATA_W-1:0]                value
);

`ifdef REGFILE_BYPASS_EN
    logic bypass_hit;
    assign bypass_hit = commit_fire && (tag_vec[addr] == commit_entry);
`else
    // Commit inputs only matter when the bypass is built in
    logic unused_bypass;
    assign unused_bypass = ^{commit_fire, commit_entry, commit_value};
`endif

    // Lookup mux: x0 -> zeros, busy -> wait tag, otherwise committed value
    always_comb begin
        busy  = FALSE;
        entry = '0;
        value = '0;
        if (!is_x0(addr)) begin
            if (busy_vec[addr]) begin
`ifdef REGFILE_BYPASS_EN
                if (bypass_hit) begin
                    value = commit_value;
                end else begin
                    busy  = TRUE;
                    entry = tag_vec[addr];
                end
`else
                busy  = TRUE;
                entry = tag_vec[addr];
`endif
            end else begin
                value = value_vec[addr];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rename_register_file.sv
`default_nettype none
// ============================================================================
// Module      : rename_register_file
// Description : Architectural register file plus rename-tag table. Issue tags
//               a destination with its ROB entry; commit writes the value and
//               releases the tag only if it still names the committing entry.
//               Optional macro: REGFILE_BYPASS_EN (commit-to-lookup bypass).
// Revision    : 1.0 - initial release
// ============================================================================
module rename_register_file
    import rename_register_file_pkg::*;
#(
    parameter int REG_NUM = 32,
    parameter int ENTRY_W = 5
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  roll_back,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic [ENTRY_W-1:0]    issue_entry,
    input  logic                  commit_valid,
    input  logic [REG_ADDR_W-1:0] commit_rd,
    input  logic [ENTRY_W-1:0]    commit_entry,
    input  logic [DATA_W-1:0]     commit_value,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic [ENTRY_W-1:0]    rs1_entry,
    output logic [ENTRY_W-1:0]    rs2_entry,
    output logic [DATA_W-1:0]     rs1_value,
    output logic [DATA_W-1:0]     rs2_value,
    output logic [DATA_W-1:0]     retired_count
);

    logic [REG_NUM-1:0][DATA_W-1:0]  regs;
    logic [REG_NUM-1:0]              busy;
    logic [REG_NUM-1:0][ENTRY_W-1:0] tags;

    logic commit_fire;
    logic issue_fire;
    logic commit_releases;

    assign commit_fire     = rdy_in && commit_valid;
    assign issue_fire      = rdy_in && issue_valid && !is_x0(issue_rd) && !roll_back;
    // Only the youngest producer may release the tag; stale commits leave it
    assign commit_releases = commit_fire && busy[commit_rd] && (tags[commit_rd] == commit_entry);

    // Architectural values and retire counter; a flush does not block commit
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            regs          <= '0;
            retired_count <= '0;
        end else if (commit_fire) begin
            if (!is_x0(commit_rd)) begin
                regs[commit_rd] <= commit_value;
            end
            retired_count <= retired_count + 32'd1;
        end
    end

    // Rename state: flush clears all, else commit release then issue (issue wins)
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            busy <= '0;
            tags <= '0;
        end else if (roll_back) begin
            busy <= '0;
            tags <= '0;
        end else begin
            if (commit_releases) begin
                busy[commit_rd] <= FALSE;
            end
            if (issue_fire) begin
                busy[issue_rd] <= TRUE;
                tags[issue_rd] <= issue_entry;
            end
        end
    end

    regfile_read_port #(
        .REG_NUM (REG_NUM),
        .ENTRY_W (ENTRY_W)
    ) u_rs1_port (
        .addr         (rs1_addr),
        .busy_vec     (busy),
        .tag_vec      (tags),
        .value_vec    (regs),
        .commit_fire  (commit_fire),
        .commit_entry (commit_entry),
        .commit_value (commit_value),
        .busy         (rs1_busy),
        .entry        (rs1_entry),
        .value        (rs1_value)
    );

    regfile_read_port #(
        .REG_NUM (REG_NUM),
        .ENTRY_W (ENTRY_W)
    ) u_rs2_port (
        .addr         (rs2_addr),
        .busy_vec     (busy),
        .tag_vec      (tags),
        .value_vec    (regs),
        .commit_fire  (commit_fire),
        .commit_entry (commit_entry),
        .commit_value (commit_value),
        .busy         (rs2_busy),
        .entry        (rs2_entry),
        .value        (rs2_value)
    );

endmodule
`default_nettype wire

// File: tb/tb_rename_register_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_rename_register_file
// Description : Directed plus randomized bench for rename_register_file with
//               a behavioural model of register values, busy flags and tags.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rename_register_file;

    localparam int EW = 5;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b0;
    logic          rdy_in, roll_back, issue_valid, commit_valid;
    logic [4:0]    issue_rd, commit_rd, rs1_addr, rs2_addr;
    logic [EW-1:0] issue_entry, commit_entry, rs1_entry, rs2_entry;
    logic [31:0]   commit_value, rs1_value, rs2_value, retired_count;
    logic          rs1_busy, rs2_busy;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural state: what each architectural register holds and waits on
    logic [31:0]   m_val  [32];
    bit            m_busy [32];
    logic [EW-1:0] m_tag  [32];
    logic [31:0]   m_cnt;

    rename_register_file #(.REG_NUM(32), .ENTRY_W(EW)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .roll_back     (roll_back),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .issue_entry   (issue_entry),
        .commit_valid  (commit_valid),
        .commit_rd     (commit_rd),
        .commit_entry  (commit_entry),
        .commit_value  (commit_value),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rs1_busy      (rs1_busy),
        .rs2_busy      (rs2_busy),
        .rs1_entry     (rs1_entry),
        .rs2_entry     (rs2_entry),
        .rs1_value     (rs1_value),
        .rs2_value     (rs2_value),
        .retired_count (retired_count)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_val[i]  = '0;
            m_busy[i] = 1'b0;
            m_tag[i]  = '0;
        end
        m_cnt = '0;
    endtask

    // Expected lookup result from the model and the current commit inputs
    task automatic expect_lookup(input logic [4:0] a, output logic b,
                                 output logic [EW-1:0] e, output logic [31:0] v);
        b = 1'b0; e = '0; v = '0;
        if (a != 0) begin
            if (!m_busy[a]) begin
                v = m_val[a];
            end else begin
`ifdef REGFILE_BYPASS_EN
                if (rdy_in && commit_valid && m_tag[a] == commit_entry) begin
                    v = commit_value;
                end else begin
                    b = 1'b1; e = m_tag[a];
                end
`else
                b = 1'b1; e = m_tag[a];
`endif
            end
        end
    endtask

    task automatic check_all(input string where);
        logic b; logic [EW-1:0] e; logic [31:0] v;
        expect_lookup(rs1_addr, b, e, v);
        chk({where, ".rs1_busy"},  {31'd0, rs1_busy},  {31'd0, b});
        chk({where, ".rs1_entry"}, {27'd0, rs1_entry}, {27'd0, e});
        chk({where, ".rs1_value"}, rs1_value, v);
        expect_lookup(rs2_addr, b, e, v);
        chk({where, ".rs2_busy"},  {31'd0, rs2_busy},  {31'd0, b});
        chk({where, ".rs2_entry"}, {27'd0, rs2_entry}, {27'd0, e});
        chk({where, ".rs2_value"}, rs2_value, v);
        chk({where, ".retired"},   retired_count, m_cnt);
    endtask

    // Apply the rules of one rising edge to the model
    task automatic clock_edge();
        @(posedge clk_in);
        if (rdy_in && commit_valid) begin
            if (commit_rd != 0) m_val[commit_rd] = commit_value;
            m_cnt = m_cnt + 1;
        end
        if (roll_back) begin
            for (int i = 0; i < 32; i++) begin
                m_busy[i] = 1'b0;
                m_tag[i]  = '0;
            end
        end else if (rdy_in) begin
            if (commit_valid && m_busy[commit_rd] && m_tag[commit_rd] == commit_entry)
                m_busy[commit_rd] = 1'b0;
            if (issue_valid && issue_rd != 0) begin
                m_busy[issue_rd] = 1'b1;
                m_tag[issue_rd]  = issue_entry;
            end
        end
        #1;
    endtask

    task automatic step(input string where);
        #1;
        check_all(where);
        clock_edge();
    endtask

    task automatic idle();
        rdy_in = 1'b1; roll_back = 1'b0;
        issue_valid = 1'b0; issue_rd = '0; issue_entry = '0;
        commit_valid = 1'b0; commit_rd = '0; commit_entry = '0; commit_value = '0;
    endtask

    task automatic do_issue(input logic [4:0] rd, input logic [EW-1:0] e);
        issue_valid = 1'b1; issue_rd = rd; issue_entry = e;
    endtask

    task automatic do_commit(input logic [4:0] rd, input logic [EW-1:0] e, input logic [31:0] v);
        commit_valid = 1'b1; commit_rd = rd; commit_entry = e; commit_value = v;
    endtask

    initial begin
        idle();
        rs1_addr = 5'd5; rs2_addr = 5'd0;
        model_reset();
        #12 rst_in = 1'b1;
        @(posedge clk_in); #1;

        // Reset state
        #1;
        chk("reset.rs1_busy",  {31'd0, rs1_busy}, 32'd0);
        chk("reset.rs1_value", rs1_value, 32'd0);
        chk("reset.rs1_entry", {27'd0, rs1_entry}, 32'd0);
        chk("reset.retired",   retired_count, 32'd0);
        step("reset");

        // Issue then commit x5
        do_issue(5'd5, 5'd3); step("issue5");
        idle(); #1;
        chk("issue5.busy",  {31'd0, rs1_busy}, 32'd1);
        chk("issue5.entry", {27'd0, rs1_entry}, 32'd3);
        do_commit(5'd5, 5'd3, 32'hDEADBEEF); step("commit5");
        idle(); #1;
        chk("commit5.busy",    {31'd0, rs1_busy}, 32'd0);
        chk("commit5.value",   rs1_value, 32'hDEADBEEF);
        chk("commit5.retired", retired_count, 32'd1);
        step("commit5.after");

        // Stale commit leaves the newer tag in place
        do_issue(5'd7, 5'd2); step("stale.i1");
        do_issue(5'd7, 5'd9); step("stale.i2");
        idle(); do_commit(5'd7, 5'd2, 32'h11); step("stale.c");
        idle(); rs1_addr = 5'd7; #1;
        chk("stale.busy",  {31'd0, rs1_busy}, 32'd1);
        chk("stale.entry", {27'd0, rs1_entry}, 32'd9);
        step("stale.after");

        // Same-cycle issue and commit to x4: issue wins busy/tag
        do_issue(5'd4, 5'd1); step("same.i1");
        do_issue(5'd4, 5'd6); do_commit(5'd4, 5'd1, 32'h22); step("same.ic");
        idle(); rs1_addr = 5'd4; #1;
        chk("same.busy",  {31'd0, rs1_busy}, 32'd1);
        chk("same.entry", {27'd0, rs1_entry}, 32'd6);
        step("same.after");

        // Flush with same-edge commit and issue
        do_issue(5'd3, 5'd10); step("rb.i3");
        do_issue(5'd8, 5'd11); step("rb.i8");
        roll_back = 1'b1; do_issue(5'd9, 5'd12); do_commit(5'd1, 5'd20, 32'h40); step("rb.edge");
        idle(); rs1_addr = 5'd3; rs2_addr = 5'd8; #1;
        chk("rb.x3_busy", {31'd0, rs1_busy}, 32'd0);
        chk("rb.x8_busy", {31'd0, rs2_busy}, 32'd0);
        rs1_addr = 5'd1; rs2_addr = 5'd9; #1;
        chk("rb.x1_value", rs1_value, 32'h40);
        chk("rb.x9_busy",  {31'd0, rs2_busy}, 32'd0);
        step("rb.after");

        // rdy_in low freezes issue and commit
        rdy_in = 1'b0; do_issue(5'd10, 5'd4); do_commit(5'd1, 5'd0, 32'h99); step("rdy.low");
        idle(); rs1_addr = 5'd10; rs2_addr = 5'd1; #1;
        chk("rdy.x10_busy", {31'd0, rs1_busy}, 32'd0);
        chk("rdy.x1_value", rs2_value, 32'h40);
        chk("rdy.retired",  retired_count, 32'd4);
        step("rdy.after");

        // x0 ignores issue and writes but commit still counts
        do_issue(5'd0, 5'd7); do_commit(5'd0, 5'd7, 32'h55); step("x0.edge");
        idle(); rs1_addr = 5'd0; #1;
        chk("x0.value",   rs1_value, 32'd0);
        chk("x0.busy",    {31'd0, rs1_busy}, 32'd0);
        chk("x0.retired", retired_count, 32'd5);
        step("x0.after");

        // Lookup of x5 while its producer commits
        do_issue(5'd5, 5'd13); step("byp.issue");
        idle(); do_commit(5'd5, 5'd13, 32'hCAFE); rs1_addr = 5'd5; #1;
`ifdef REGFILE_BYPASS_EN
        chk("byp.busy",  {31'd0, rs1_busy}, 32'd0);
        chk("byp.value", rs1_value, 32'hCAFE);
`else
        chk("byp.busy",  {31'd0, rs1_busy}, 32'd1);
        chk("byp.entry", {27'd0, rs1_entry}, 32'd13);
`endif
        step("byp.edge");

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            idle();
            rdy_in    = ($urandom_range(0, 9) != 0);
            roll_back = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 1) == 1) do_issue(5'($urandom), EW'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                commit_rd = 5'($urandom);
                do_commit(commit_rd,
                          ($urandom_range(0, 2) != 0) ? m_tag[commit_rd] : EW'($urandom),
                          $urandom);
            end
            rs1_addr = ($urandom_range(0, 1) == 1) ? issue_rd : 5'($urandom);
            rs2_addr = ($urandom_range(0, 1) == 1) ? commit_rd : 5'($urandom);
            step("rand");
        end

        // Asynchronous reset in the middle of a flush, between edges
        idle(); roll_back = 1'b1; do_issue(5'd6, 5'd5); rs1_addr = 5'd5; rs2_addr = 5'd6;
        #2 rst_in = 1'b0;
        model_reset();
        #1;
        chk("async.retired", retired_count, 32'd0);
        check_all("async");
        rst_in = 1'b1;
        idle();
        clock_edge();
        step("async.after");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rename_register_file.md
Name: rename_register_file

Overview:
- Architectural register file plus rename-tag table; the consumer of the reorder buffer's commit broadcast.
- At issue, the destination register is tagged with the issuing ROB entry.
- At commit, the value is written and the tag is released only if it still names the committing entry.
- Two source lookups give the decoder/RS either a committed value or the ROB entry to wait on.

Parameters:
- REG_NUM, 32, number of architectural registers (x0 hard-wired to zero)
- ENTRY_W, 5, ROB entry index width (matches ROB_SIZE 32)

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset, asynchronous, active-low
- rdy_in  input  1  pause when low
- roll_back  input  1  flush from branch mispredict
- issue_valid  input  1  rename destination this cycle
- issue_rd  input  5  destination register of issuing instruction
- issue_entry  input  ENTRY_W  ROB entry allocated to it (ROB cur_entry)
- commit_valid  input  1  ROB rob_commit
- commit_rd  input  5  ROB rob_des_commit[4:0]
- commit_entry  input  ENTRY_W  ROB rob_entry_commit
- commit_value  input  32  ROB rob_result_out
- rs1_addr, rs2_addr  input  5 each  source lookups
- rs1_busy, rs2_busy  output  1 each  source awaits a ROB result
- rs1_entry, rs2_entry  output  ENTRY_W each  producing ROB entry, 0 when not busy
- rs1_value, rs2_value  output  32 each  committed value, 0 when busy
- retired_count  output  32  registered count of commits with commit_valid

Behaviour:
- Async reset (rst_in low): all registers 0, all busy 0, all tags 0, retired_count 0. Takes effect immediately, including mid-flush.
- Lookups are combinational on current state:
  - busy=1 → value 0, entry = tag.
  - busy=0 → value = reg, entry 0.
  - Address 0 → value 0, busy 0, entry 0.
- rdy_in low: no state change from issue or commit; roll_back is still honoured.
- Commit, on a rising edge with rdy_in high and commit_valid:
  - Write commit_value to commit_rd when commit_rd != 0.
  - Clear busy[commit_rd] only if busy and tag == commit_entry.
  - retired_count += 1, wrapping at 2^32.
- Issue, on a rising edge with rdy_in high, issue_valid, issue_rd != 0 and no roll_back: busy[issue_rd] <= 1, tag[issue_rd] <= issue_entry.
- Issue and commit to the same rd in one cycle: the value is written; issue wins busy/tag, so busy stays 1 with the new tag.
- Issue and lookup of the same register in one cycle: the lookup returns pre-issue state. Operands are read before the instruction's own rename.
- roll_back on an edge: all busy bits and tags cleared, issue ignored. A same-edge commit still writes its value and counts, because the committing branch/jal may write rd.
- Tags are never compared against invalid entries; no NULL encoding is needed because busy qualifies the tag.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: each lookup hit with busy=1 and tag == commit_entry, while commit_valid and rdy_in are high, returns busy 0, entry 0, value commit_value. This saves one cycle of RS wakeup.
- Undefined: lookups see registered state only; the RS must capture the same commit through the ROB broadcast.

Decomposition:
- The shared header operaType.v gets `TRUE, `FALSE, `ENTRY_RANGE and new `REG_RANGE (4:0).
- One sub-module, regfile_read_port, instantiated twice. It holds the combinational lookup and the optional bypass mux, taking busy/tag/value vectors by index.

Test Plan:
- Reset, then rs1_addr=5 → busy 0, value 0, entry 0; retired_count 0.
- Issue rd=5 entry=3; next cycle rs1_addr=5 → busy 1, entry 3. Commit rd=5 entry=3 value 0xDEADBEEF → next cycle busy 0, value 0xDEADBEEF, retired_count 1.
- Stale commit: issue rd=7 entry 2, then issue rd=7 entry 9; commit rd=7 entry 2 value 0x11 → reg7=0x11 but busy 1, entry 9.
- Same-cycle issue rd=4 entry 6 and commit rd=4 entry 1 (tag was 1) value 0x22 → reg4=0x22, busy 1, entry 6.
- roll_back with x3, x8 busy and same-edge commit rd=1 value 0x40 → all busy 0, reg1=0x40. An issue on that edge leaves no tag.
- rdy_in low with commit/issue valid → no change. Writes to x0 are ignored and x0 reads 0. With REGFILE_BYPASS_EN, lookup of x5 during its commit returns the commit value with busy 0.
